// File: rtl/product_window_accumulator.sv
// Windowed accumulator for (a+b)*(c+d) product samples: sum, count and max per window, held until accepted.
// Optional build macro PRODUCT_ACC_SATURATE_EN clamps the sum on carry-out instead of wrapping.
module product_window_accumulator #(
   parameter int unsigned N     = 8,
   parameter int unsigned SUM_W = 12,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic [7:0]       out_max,
   output logic             out_ovf
);

   typedef enum logic {ACCUM, HOLD} state_e;

   state_e           state_q;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       max_q, max_d;
   logic             ovf_q, ovf_d;
   logic [SUM_W:0]   sum_ext;
   logic             accept;
   logic             close;

   // Reset is folded in so no sample can be offered as accepted during the reset cycle.
   always_comb begin
      in_ready = (state_q == ACCUM) && !reset;
   end

   always_comb begin
      accept  = in_valid && in_ready;
      sum_ext = {1'b0, acc_q} + {{(SUM_W-7){1'b0}}, in_data};
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      ovf_d   = ovf_q;
      if (accept) begin
`ifdef PRODUCT_ACC_SATURATE_EN
         acc_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`else
         acc_d = sum_ext[SUM_W-1:0];
`endif
         cnt_d = cnt_q + CNT_W'(1);
         if (in_data > max_q) max_d = in_data;
         ovf_d = ovf_q | sum_ext[SUM_W];
      end
      close = (accept && (cnt_q == CNT_W'(N - 1)))
           || (flush && in_ready && ((cnt_q != '0) || accept));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         max_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_max   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (close) begin
                  out_sum   <= acc_d;
                  out_count <= cnt_d;
                  out_max   <= max_d;
                  out_ovf   <= ovf_d;
                  out_valid <= 1'b1;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  max_q     <= '0;
                  ovf_q     <= 1'b0;
                  state_q   <= HOLD;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  max_q <= max_d;
                  ovf_q <= ovf_d;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_product_window_accumulator.sv
// Directed bench for product_window_accumulator: two instances (N=8/SUM_W=12 and N=4/SUM_W=8).
module tb_product_window_accumulator;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // Instance A: N=8, SUM_W=12, CNT_W=8
   logic        a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b1, a_out_ovf;
   logic [7:0]  a_in_data = '0, a_out_count, a_out_max;
   logic [11:0] a_out_sum;
   // Instance B: N=4, SUM_W=8, CNT_W=8
   logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b1, b_out_ovf;
   logic [7:0]  b_in_data = '0, b_out_count, b_out_max, b_out_sum;

   logic [29:0] a_res;
   logic [25:0] b_res;
   assign a_res = {a_out_valid, a_out_sum, a_out_count, a_out_max, a_out_ovf};
   assign b_res = {b_out_valid, b_out_sum, b_out_count, b_out_max, b_out_ovf};

   int checks   = 0;
   int failures = 0;

   product_window_accumulator #(.N(8), .SUM_W(12), .CNT_W(8)) u_a (
      .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_count(a_out_count), .out_max(a_out_max), .out_ovf(a_out_ovf));

   product_window_accumulator #(.N(4), .SUM_W(8), .CNT_W(8)) u_b (
      .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_count(b_out_count), .out_max(b_out_max), .out_ovf(b_out_ovf));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_in_ready, a_res} !== 31'd0) begin
         failures++; $display("FAIL reset_state got ready=%0d res=%h required ready=0 res=0", a_in_ready, a_res);
      end
      checks++;
      if ({b_in_ready, b_res} !== 27'd0) begin
         failures++; $display("FAIL reset_state_b got ready=%0d res=%h required 0", b_in_ready, b_res);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({a_in_ready, b_in_ready} !== 2'b11) begin
         failures++; $display("FAIL ready_after_reset got %b required 11", {a_in_ready, b_in_ready});
      end
   endtask

   task automatic test_stream();
      a_out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'(i);
         if (i == 8) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
               failures++; $display("FAIL stream_early_valid got %0d required 0", a_out_valid);
            end
         end
         tick();
      end
      a_in_valid = 1'b0;
      checks++;
      if ({a_in_ready, a_res} !== {1'b0, 1'b1, 12'd36, 8'd8, 8'd8, 1'b0}) begin
         failures++; $display("FAIL stream_result got ready=%0d res=%h required ready=0 v=1 sum=36 cnt=8 max=8 ovf=0", a_in_ready, a_res);
      end
      tick();
      checks++;
      if ({a_in_ready, a_out_valid, a_out_sum} !== {1'b1, 1'b0, 12'd36}) begin
         failures++; $display("FAIL stream_one_cycle got ready=%0d valid=%0d sum=%0d required 1 0 36", a_in_ready, a_out_valid, a_out_sum);
      end
   endtask

   task automatic test_back_to_back();
      a_out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'(10 + i);
         tick();
      end
      a_in_data = 8'd50;  // in_valid stays high through HOLD; this sample must survive
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({a_in_ready, a_res} !== {1'b0, 1'b1, 12'd116, 8'd8, 8'd18, 1'b0}) begin
            failures++; $display("FAIL backpressure_hold[%0d] got ready=%0d res=%h required ready=0 v=1 sum=116 cnt=8 max=18", k, a_in_ready, a_res);
         end
         if (k < 4) tick();
      end
      a_out_ready = 1'b1;
      tick();
      checks++;
      if ({a_in_ready, a_res} !== {1'b1, 1'b0, 12'd116, 8'd8, 8'd18, 1'b0}) begin
         failures++; $display("FAIL backpressure_release got ready=%0d res=%h required ready=1 v=0 result kept", a_in_ready, a_res);
      end
      tick();
      for (int i = 0; i < 7; i++) begin
         a_in_data = 8'd1;
         tick();
      end
      a_in_valid = 1'b0;
      checks++;
      if (a_res !== {1'b1, 12'd57, 8'd8, 8'd50, 1'b0}) begin
         failures++; $display("FAIL backpressure_no_loss got %h required v=1 sum=57 cnt=8 max=50", a_res);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [7:0] vals [4];
      vals[0] = 8'd3; vals[1] = 8'd7; vals[2] = 8'd5; vals[3] = 8'd2;
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_in_valid = 1'b1; a_in_data = vals[i]; a_flush = (i == 3);
         tick();
      end
      a_in_valid = 1'b0; a_flush = 1'b0;
      checks++;
      if (a_res !== {1'b1, 12'd17, 8'd4, 8'd7, 1'b0}) begin
         failures++; $display("FAIL flush_with_sample got %h required v=1 sum=17 cnt=4 max=7", a_res);
      end
      tick();
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_empty_ignored got valid=%0d required 0", a_out_valid);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_empty_late got valid=%0d required 0", a_out_valid);
      end
      a_in_valid = 1'b1; a_in_data = 8'd9;
      tick();
      a_in_valid = 1'b0; a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      checks++;
      if (a_res !== {1'b1, 12'd9, 8'd1, 8'd9, 1'b0}) begin
         failures++; $display("FAIL flush_alone got %h required v=1 sum=9 cnt=1 max=9", a_res);
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_sum;
`ifdef PRODUCT_ACC_SATURATE_EN
      exp_sum = 8'd255;
`else
      exp_sum = 8'd144;
`endif
      b_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_in_valid = 1'b1; b_in_data = 8'd100;
         tick();
      end
      b_in_valid = 1'b0;
      checks++;
      if (b_res !== {1'b1, exp_sum, 8'd4, 8'd100, 1'b1}) begin
         failures++; $display("FAIL overflow got %h required v=1 sum=%0d cnt=4 max=100 ovf=1", b_res, exp_sum);
      end
      tick();
      for (int i = 1; i <= 4; i++) begin
         b_in_valid = 1'b1; b_in_data = 8'(i);
         tick();
      end
      b_in_valid = 1'b0;
      checks++;
      if (b_res !== {1'b1, 8'd10, 8'd4, 8'd4, 1'b0}) begin
         failures++; $display("FAIL overflow_cleared got %h required v=1 sum=10 cnt=4 max=4 ovf=0", b_res);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'd196;
         tick();
      end
      a_in_valid = 1'b0; reset = 1'b1;
      tick();
      checks++;
      if (a_res !== 30'd0) begin
         failures++; $display("FAIL reset_mid_window got %h required 0", a_res);
      end
      reset = 1'b0;
      a_out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'd7;
         tick();
      end
      a_in_valid = 1'b0;
      checks++;
      if (a_res !== {1'b1, 12'd56, 8'd8, 8'd7, 1'b0}) begin
         failures++; $display("FAIL partial_discarded got %h required v=1 sum=56 cnt=8 max=7", a_res);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({a_in_ready, a_res} !== 31'd0) begin
         failures++; $display("FAIL reset_in_hold got ready=%0d res=%h required 0", a_in_ready, a_res);
      end
      reset = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1; a_in_data = 8'd196;
         tick();
      end
      a_in_valid = 1'b0;
      checks++;
      if (a_res !== {1'b1, 12'd1568, 8'd8, 8'd196, 1'b0}) begin
         failures++; $display("FAIL after_reset_window got %h required v=1 sum=1568 cnt=8 max=196", a_res);
      end
      tick();
   endtask

   task automatic test_random();
      logic [27:0] expq[$];
      logic [27:0] exp_r;
      int m_sum = 0, m_cnt = 0, m_max = 0, accepted = 0, results = 0, cycles = 0;
      while (accepted < 1000 && cycles < 20000) begin
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_data   = 8'($urandom_range(0, 255));
         a_out_ready = 1'($urandom_range(0, 1));
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               failures++; $display("FAIL random_unexpected got sum=%0d cnt=%0d required no result", a_out_sum, a_out_count);
            end else begin
               exp_r = expq.pop_front();
               results++;
               if ({a_out_sum, a_out_count, a_out_max} !== exp_r) begin
                  failures++; $display("FAIL random_result[%0d] got sum=%0d cnt=%0d max=%0d required sum=%0d cnt=%0d max=%0d",
                     results, a_out_sum, a_out_count, a_out_max, exp_r[27:16], exp_r[15:8], exp_r[7:0]);
               end
            end
         end
         if (a_in_valid && a_in_ready) begin
            accepted++;
            m_sum += a_in_data; m_cnt++;
            if (a_in_data > m_max) m_max = a_in_data;
            if (m_cnt == 8) begin
               expq.push_back({12'(m_sum), 8'(m_cnt), 8'(m_max)});
               m_sum = 0; m_cnt = 0; m_max = 0;
            end
         end
         tick();
         cycles++;
      end
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      for (int k = 0; k < 4 && expq.size() != 0; k++) begin
         if (a_out_valid) begin
            exp_r = expq.pop_front();
            results++;
            checks++;
            if ({a_out_sum, a_out_count, a_out_max} !== exp_r) begin
               failures++; $display("FAIL random_drain got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, exp_r[27:16], exp_r[15:8]);
            end
         end
         tick();
      end
      checks++;
      if (results != 125 || accepted != 1000) begin
         failures++; $display("FAIL random_totals got results=%0d accepted=%0d required 125 1000", results, accepted);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_back_to_back();
      test_flush();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/product_window_accumulator.md
# product_window_accumulator

Downstream consumer of the 8-bit `(a+b)*(c+d)` pipeline product. Accepts product samples over a valid/ready handshake, accumulates a window of `N` samples (or fewer on `flush`), tracks the window maximum, and presents sum, sample count and maximum as one result held until the sink accepts it. Backpressure reaches the producer through `in_ready` while a result is pending.

## Interface
- `N`, 8: samples per window; legal range 2 to 2^`CNT_W`-1.
- `SUM_W`, 12: width of the accumulator and `out_sum`.
- `CNT_W`, 8: width of the sample counter and `out_count`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries a sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_data`  in  8  unsigned product sample.
- `flush`  in  1  close the current window early.
- `out_valid`  out  1  result registers are valid.
- `out_ready`  in  1  sink accepts the result.
- `out_sum`  out  `SUM_W`  window sum.
- `out_count`  out  `CNT_W`  samples in the window, 1..`N`.
- `out_max`  out  8  largest sample in the window.
- `out_ovf`  out  1  sum exceeded 2^`SUM_W`-1 during the window.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- `in_ready` = 1 in ACCUM and 0 in HOLD. This is a registered-state decode with no combinational path from `out_ready`.
- A sample is accepted on any cycle where `in_valid && in_ready`.
- **On acceptance:**
  - `acc` <= `acc` + `in_data`, zero-extended to `SUM_W + 1` bits before the add.
  - `cnt` <= `cnt` + 1.
  - `max` <= larger of `max` and `in_data`.
  - `ovf` is set sticky if the add carries out of `SUM_W` bits. Overflow handling is set by Configuration.
- **Window close (ACCUM to HOLD).** The window closes when either:
  - a sample is accepted with `cnt` == `N`-1, or
  - `flush` = 1 with (`cnt` > 0 or a sample is accepted that cycle).
- **On window close:**
  - The close-cycle sample is included in the result.
  - `out_sum`, `out_count`, `out_max` and `out_ovf` load the post-update values.
  - Internal `acc`, `cnt`, `max` and `ovf` clear to 0.
- `flush` with `cnt` == 0 and no sample accepted is ignored.
- `flush` in HOLD is ignored and is not remembered.
- **HOLD to ACCUM** when `out_ready` = 1. The result registers are left unchanged; only `out_valid` drops.
- **Reset outputs:** `out_valid`=0, `out_sum`=0, `out_count`=0, `out_max`=0, `out_ovf`=0. `in_ready` is 0 during the reset cycle and 1 afterwards.
- A reset mid-window or in HOLD discards the partial window and the pending result.

## Timing
- `out_valid` rises in the cycle after the closing sample or flush is accepted. Latency is 1 clock.
- `out_valid` stays high, and the result is stable, until the first edge where `out_ready` = 1.
- `in_ready` rises in the cycle after the handshake completes, so there is one dead input cycle per window.
- Peak throughput is `N` samples per `N`+1 cycles when `out_ready` is held high.
- `in_data` and `flush` are sampled only on the clock edge. `in_data` is ignored when `in_valid` = 0.
- The `out_ready` value in the close cycle has no effect, because the state is still ACCUM.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined:
  - On carry-out, `acc` clamps to 2^`SUM_W`-1 and remains clamped for the rest of the window.
  - `out_ovf` is set.
- `PRODUCT_ACC_SATURATE_EN` undefined:
  - `acc` wraps modulo 2^`SUM_W`.
  - `out_ovf` is still set on any carry-out.

## Test plan
- Reset, then `N`=8, `SUM_W`=12: stream 1..8 with `out_ready`=1.
  - Required: `out_sum`=36, `out_count`=8, `out_max`=8, `out_ovf`=0.
  - `out_valid` for exactly 1 cycle; `in_ready` low for exactly 1 cycle.
- Backpressure: close a window with `out_ready`=0 for 5 cycles.
  - Required: `out_valid` and the result stay stable.
  - `in_ready`=0 throughout; `in_valid` held high loses no samples.
- Flush: accept 3, 7, 5, then pulse `flush` with sample 2 in the same cycle.
  - Required: `out_sum`=17, `out_count`=4, `out_max`=7.
  - Also: `flush` with `cnt`=0 and no sample produces no `out_valid`.
- Overflow: `N`=4, `SUM_W`=8, four samples of 100.
  - Required with `PRODUCT_ACC_SATURATE_EN` defined: `out_sum`=255.
  - Required without it: `out_sum`=144.
  - `out_ovf`=1 in both builds, and the next window starts with `out_ovf` clear.
- Reset mid-window (after 5 samples) and again in HOLD.
  - Required: all outputs read 0 the next cycle.
  - The following window of `N` samples of 196 gives `out_sum`=1568 and `out_max`=196.
- Random-gap `in_valid` and random `out_ready` over 1000 samples against a reference model.
  - Required: the sum and count of every result match the model.
